serial_word_collector: RTL

Serial-to-parallel collector for the practice datapath: the inverse of the 8:1 bit selector. It accepts one bit per handshake in selector order (position 0 first), reassembles a WIDTH-bit word, and presents it on a valid/ready output register. The output register carries the same status the combinational checks produce: the most-significant set bit index, a zero flag and a multiple-ones flag. It sits between a serial bit source and the word-level combinational blocks.

---
 rtl/serial_word_collector.sv | 88 ++++++++
 1 files changed

// File: rtl/serial_word_collector.sv
// Serial-to-parallel collector: gathers WIDTH bits LSB first over a valid/ready
// handshake and presents the word with msb/zero/multi status on an output register.
module serial_word_collector #(
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_start,
  output logic             in_ready,
  output logic [SEL_W-1:0] in_index,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_values,
  output logic [SEL_W-1:0] out_msb,
  output logic             out_zero,
  output logic             out_multi
);

  localparam logic [0:0]       IDLE    = 1'b0;
  localparam logic [0:0]       COLLECT = 1'b1;
  localparam logic [SEL_W-1:0] LAST    = SEL_W'(WIDTH - 1);

  logic [0:0]       state;
  logic [SEL_W-1:0] index_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] next_shift;
  logic             accept;
  logic             restart;
  logic             complete;

  function automatic logic [SEL_W-1:0] msb_of(input logic [WIDTH-1:0] w);
    msb_of = '0;
    for (int i = 0; i < WIDTH; i++)
      if (w[i]) msb_of = SEL_W'(i);
  endfunction

  // A completing beat stalls only while a held word is still unread.
  assign in_ready = !(state == COLLECT && index_q == LAST && out_valid && !out_ready);
  assign in_index = index_q;
  assign accept   = in_valid && in_ready;
  assign restart  = (state == IDLE) || in_start;
  assign complete = accept && !restart && (index_q == LAST);

  always_comb begin
    // NOTE: assign a default first so every path drives next_shift; otherwise a latch is inferred.
    next_shift = shift_q;
    if (restart) next_shift = {{(WIDTH-1){1'b0}}, in_bit};
    else         next_shift[index_q] = in_bit;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state      <= IDLE;
      index_q    <= '0;
      shift_q    <= '0;
      out_valid  <= 1'b0;
      out_values <= '0;
      out_msb    <= '0;
      out_zero   <= 1'b0;
      out_multi  <= 1'b0;
    end else begin
      if (accept) begin
        shift_q <= next_shift;
        if (complete) begin
          state   <= IDLE;
          index_q <= '0;
        end else begin
          state   <= COLLECT;
          index_q <= restart ? SEL_W'(1) : index_q + 1'b1;
        end
      end
      if (complete) begin
        out_valid  <= 1'b1;
        out_values <= next_shift;
        out_msb    <= msb_of(next_shift);
        out_zero   <= (next_shift == '0);
        out_multi  <= |(next_shift & (next_shift - 1'b1));
      end else if (out_valid && out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule
